// File: rtl/rf_wb_arb.sv
// rtl/rf_wb_arb.sv - two-requester register-file writeback arbiter with anti-starvation priority
// A wins by default; B is forced ahead after MAXWAIT consecutive denied cycles.
module rf_wb_arb #(
  parameter int unsigned MAXWAIT = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        A_VALID,
  input  logic [4:0]  A_NUM,
  input  logic [31:0] A_DATA,
  output logic        A_READY,
  input  logic        B_VALID,
  input  logic [4:0]  B_NUM,
  input  logic [31:0] B_DATA,
  output logic        B_READY,
  output logic [4:0]  WNUM,
  output logic [31:0] WDATA,
  output logic        PRIO_B
);

  localparam logic [3:0] L_MAXWAIT = 4'(MAXWAIT);

  typedef enum logic {S_PRIO_A, S_PRIO_B} state_t;

  state_t      r_state;
  logic [3:0]  r_wait;
  logic [4:0]  r_wnum;
  logic [31:0] r_wdata;

  logic        w_a_nz;
  logic        w_b_nz;
  logic        w_a_grant;
  logic        w_b_grant;
  logic        w_b_denied;
  logic        w_b_clear;
  logic [3:0]  w_wait_inc;

  assign w_a_nz = A_VALID && (A_NUM != 5'd0);
  assign w_b_nz = B_VALID && (B_NUM != 5'd0);

  // Only nonzero requests compete for the port; zero-index ones are simply absorbed.
  assign w_a_grant = !RST && w_a_nz && ((r_state == S_PRIO_A) || !w_b_nz);
  assign w_b_grant = !RST && w_b_nz && ((r_state == S_PRIO_B) || !w_a_nz);

  assign A_READY = !RST && A_VALID && ((A_NUM == 5'd0) || w_a_grant);
  assign B_READY = !RST && B_VALID && ((B_NUM == 5'd0) || w_b_grant);

  assign w_b_denied = w_b_nz && !w_b_grant;
  assign w_b_clear  = !B_VALID || B_READY;
  assign w_wait_inc = (r_wait == 4'hF) ? 4'hF : r_wait + 4'd1;

  assign WNUM   = r_wnum;
  assign WDATA  = r_wdata;
  assign PRIO_B = (r_state == S_PRIO_B);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_PRIO_A;
      r_wait  <= 4'd0;
      r_wnum  <= 5'd0;
      r_wdata <= 32'd0;
    end else begin
      if (w_a_grant) begin
        r_wnum  <= A_NUM;
        r_wdata <= A_DATA;
      end else if (w_b_grant) begin
        r_wnum  <= B_NUM;
        r_wdata <= B_DATA;
      end else begin
        r_wnum  <= 5'd0;
      end

      if (w_b_clear) begin
        r_wait <= 4'd0;
      end else if (w_b_denied) begin
        r_wait <= w_wait_inc;
      end

      case (r_state)
        S_PRIO_A: if (w_b_denied && (w_wait_inc == L_MAXWAIT)) r_state <= S_PRIO_B;
        S_PRIO_B: if (w_b_clear) r_state <= S_PRIO_A;
        default:  r_state <= S_PRIO_A;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wb_arb.sv
// tb/tb_rf_wb_arb.sv - directed vector bench for rf_wb_arb
module tb_rf_wb_arb;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        A_VALID = 1'b0;
  logic [4:0]  A_NUM = 5'd0;
  logic [31:0] A_DATA = 32'd0;
  logic        A_READY;
  logic        B_VALID = 1'b0;
  logic [4:0]  B_NUM = 5'd0;
  logic [31:0] B_DATA = 32'd0;
  logic        B_READY;
  logic [4:0]  WNUM;
  logic [31:0] WDATA;
  logic        PRIO_B;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  rf_wb_arb #(.MAXWAIT(3)) dut (
    .CLK(CLK), .RST(RST),
    .A_VALID(A_VALID), .A_NUM(A_NUM), .A_DATA(A_DATA), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_NUM(B_NUM), .B_DATA(B_DATA), .B_READY(B_READY),
    .WNUM(WNUM), .WDATA(WDATA), .PRIO_B(PRIO_B)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  an;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  bn;
    logic [31:0] bd;
    logic        exp_ar;
    logic        exp_br;
    logic [4:0]  exp_wnum;
    logic [31:0] exp_wdata;
    logic        exp_prio;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic av, input logic [4:0] an, input logic [31:0] ad,
                       input logic bv, input logic [4:0] bn, input logic [31:0] bd);
    RST = rst; A_VALID = av; A_NUM = an; A_DATA = ad;
    B_VALID = bv; B_NUM = bn; B_DATA = bd;
  endtask

  initial begin
    // Each row is one clock: ready flags sampled before the edge, write port and priority after it.
    vecs[0]  = '{1'b1, 1'b1, 5'd5, 32'h0000_0001, 1'b1, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 5'd5, 32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h1234_5678, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 5'd7, 32'hAAAA_AAAA, 1'b1, 5'd7, 32'hBBBB_BBBB, 1'b1, 1'b0, 5'd7, 32'hAAAA_AAAA, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 32'hBBBB_BBBB, 1'b0, 1'b1, 5'd7, 32'hBBBB_BBBB, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 32'hBBBB_BBBB, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd3, 32'h33, 1'b1, 1'b1, 5'd3, 32'h33,        1'b0};
    vecs[7]  = '{1'b0, 1'b1, 5'd0, 32'h1111_1111, 1'b1, 5'd0, 32'h22, 1'b1, 1'b1, 5'd0, 32'h33,        1'b0};
    vecs[8]  = '{1'b0, 1'b1, 5'd4, 32'h44,        1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 5'd4, 32'h44,        1'b0};
    vecs[9]  = '{1'b1, 1'b1, 5'd4, 32'h44,        1'b1, 5'd3, 32'h3,  1'b0, 1'b0, 5'd0, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 1'b1, 5'd1, 32'h1,         1'b1, 5'd2, 32'h2,  1'b1, 1'b0, 5'd1, 32'h1,         1'b0};
    vecs[12] = '{1'b0, 1'b1, 5'd1, 32'h1,         1'b1, 5'd2, 32'h2,  1'b1, 1'b0, 5'd1, 32'h1,         1'b0};
    vecs[13] = '{1'b0, 1'b1, 5'd1, 32'h1,         1'b1, 5'd2, 32'h2,  1'b1, 1'b0, 5'd1, 32'h1,         1'b1};
    vecs[14] = '{1'b0, 1'b1, 5'd1, 32'h5,         1'b0, 5'd2, 32'h2,  1'b1, 1'b0, 5'd1, 32'h5,         1'b0};
    vecs[15] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h5,         1'b0};

    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      drive(vecs[i].rst, vecs[i].av, vecs[i].an, vecs[i].ad, vecs[i].bv, vecs[i].bn, vecs[i].bd);
      #2;
      chk($sformatf("vec%0d A_READY", i), 32'(A_READY), 32'(vecs[i].exp_ar));
      chk($sformatf("vec%0d B_READY", i), 32'(B_READY), 32'(vecs[i].exp_br));
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d WNUM", i), 32'(WNUM), 32'(vecs[i].exp_wnum));
      chk($sformatf("vec%0d WDATA", i), WDATA, vecs[i].exp_wdata);
      chk($sformatf("vec%0d PRIO_B", i), 32'(PRIO_B), 32'(vecs[i].exp_prio));
    end

    // Starvation: A streams nonzero writes, B(9) held until it is forced through.
    @(negedge CLK);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      drive(1'b0, 1'b1, 5'(10 + c), 32'(c), (c < 4), 5'd9, 32'h99);
      #2;
      chk($sformatf("starve c%0d A_READY", c), 32'(A_READY), (c == 3) ? 32'd0 : 32'd1);
      chk($sformatf("starve c%0d B_READY", c), 32'(B_READY), (c == 3) ? 32'd1 : 32'd0);
      chk($sformatf("starve c%0d PRIO_B", c), 32'(PRIO_B), (c == 3) ? 32'd1 : 32'd0);
      if (c == 0) chk("starve c0 WNUM", 32'(WNUM), 32'd0);
      else if (c == 4) chk("starve c4 WNUM", 32'(WNUM), 32'd9);
      else chk($sformatf("starve c%0d WNUM", c), 32'(WNUM), 32'(9 + c));
    end
    #1;
    chk("starve c4 WDATA", WDATA, 32'h99);

    // Streaming: A accepted every cycle, writes appear with no bubble.
    @(negedge CLK);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int n = 1; n <= 8; n++) begin
      @(negedge CLK);
      drive(1'b0, 1'b1, 5'(n), 32'(n * 32'h1111), 1'b0, 5'd0, 32'h0);
      @(posedge CLK);
      #1;
      chk($sformatf("stream %0d WNUM", n), 32'(WNUM), 32'(n));
      chk($sformatf("stream %0d WDATA", n), WDATA, 32'(n * 32'h1111));
    end
    @(negedge CLK);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge CLK);
    #1;
    chk("stream end WNUM", 32'(WNUM), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
